// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// A request is arbitrated and accepted in IDLE, and its operands are captured.
// They are then held on the ALU for one cycle, or MUL_CYCLES cycles for
// multiply (ctrl 3'b101). The registered result is returned over a valid/ready
// response channel, tagged with the requester id.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie-breaking;
// otherwise requester 0 has fixed priority.
module alu_share_arb #(
   parameter int unsigned MUL_CYCLES = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [31:0] req0_data1_i,
   input  logic [31:0] req0_data2_i,
   input  logic [2:0]  req0_ctrl_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [31:0] req1_data1_i,
   input  logic [31:0] req1_data2_i,
   input  logic [2:0]  req1_ctrl_i,
   output logic [31:0] alu_data1_o,
   output logic [31:0] alu_data2_o,
   output logic [2:0]  alu_ctrl_o,
   input  logic [31:0] alu_result_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [31:0] rsp_data_o
);

   localparam logic [2:0] CtrlMul = 3'b101;
   // Counter preload for multiply; holding operands MUL_CYCLES cycles means N-1 extra.
   localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e      state_q;
   logic [31:0] op1_q, op2_q;
   logic [2:0]  ctrl_q;
   logic [3:0]  cnt_q;
   logic        last_grant_q;
   logic        rsp_id_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_data_q;

   logic        grant_id;
   logic        accept;
   logic [31:0] sel_data1, sel_data2;
   logic [2:0]  sel_ctrl;
   logic [3:0]  cnt_load;

   // Arbitration, combinational ready and selection of the granted requester's operands.
   always_comb begin
`ifdef ALU_ARB_RR_EN
      grant_id = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
`else
      grant_id = ~req0_valid_i;
`endif
      // Reset gating keeps ready low while rst_i is asserted even if a requester is valid.
      accept       = (state_q == StIdle) && !rst_i && (req0_valid_i || req1_valid_i);
      req0_ready_o = accept && !grant_id;
      req1_ready_o = accept && grant_id;
      sel_data1    = grant_id ? req1_data1_i : req0_data1_i;
      sel_data2    = grant_id ? req1_data2_i : req0_data2_i;
      sel_ctrl     = grant_id ? req1_ctrl_i  : req0_ctrl_i;
      cnt_load     = (sel_ctrl == CtrlMul) ? MulLoad : 4'd0;
   end

   // Control FSM with operand, counter and response registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         op1_q        <= '0;
         op2_q        <= '0;
         ctrl_q       <= '0;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  op1_q        <= sel_data1;
                  op2_q        <= sel_data2;
                  ctrl_q       <= sel_ctrl;
                  cnt_q        <= cnt_load;
                  last_grant_q <= grant_id;
                  rsp_id_q     <= grant_id;
                  state_q      <= StExec;
               end
            end
            StExec: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  rsp_data_q  <= alu_result_i;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // The operand registers drive the ALU; they only change on acceptance, so they stay stable in EXEC.
   assign alu_data1_o = op1_q;
   assign alu_data2_o = op2_q;
   assign alu_ctrl_o  = ctrl_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU model (MUL_CYCLES = 3).
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_data1, req0_data2;
   logic [2:0]  req0_ctrl;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_data1, req1_data2;
   logic [2:0]  req1_ctrl;
   logic [31:0] alu_data1, alu_data2, alu_result;
   logic [2:0]  alu_ctrl;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_data;

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_ids;

   always #5 clk = ~clk;

   alu_share_arb #(.MUL_CYCLES(3)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_valid_i (req0_valid),
      .req0_ready_o (req0_ready),
      .req0_data1_i (req0_data1),
      .req0_data2_i (req0_data2),
      .req0_ctrl_i  (req0_ctrl),
      .req1_valid_i (req1_valid),
      .req1_ready_o (req1_ready),
      .req1_data1_i (req1_data1),
      .req1_data2_i (req1_data2),
      .req1_ctrl_i  (req1_ctrl),
      .alu_data1_o  (alu_data1),
      .alu_data2_o  (alu_data2),
      .alu_ctrl_o   (alu_ctrl),
      .alu_result_i (alu_result),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_id_o     (rsp_id),
      .rsp_data_o   (rsp_data)
   );

   // External ALU model: 011 add, 100 sub, 101 mul, 110 arithmetic shift right, 111 zero.
   always_comb begin
      alu_result = 32'd0;
      case (alu_ctrl)
         3'b000: alu_result = alu_data1 & alu_data2;
         3'b001: alu_result = alu_data1 | alu_data2;
         3'b010: alu_result = alu_data1 ^ alu_data2;
         3'b011: alu_result = alu_data1 + alu_data2;
         3'b100: alu_result = alu_data1 - alu_data2;
         3'b101: alu_result = alu_data1 * alu_data2;
         3'b110: alu_result = $signed(alu_data1) >>> alu_data2[4:0];
         default: alu_result = 32'd0;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
      check({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
      check({tag, "_alu1"}, alu_data1, 32'd0);
      check({tag, "_alu2"}, alu_data2, 32'd0);
      check({tag, "_aluc"}, 32'(alu_ctrl), 32'd0);
      check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rspid"}, 32'(rsp_id), 32'd0);
      check({tag, "_rspd"}, rsp_data, 32'd0);
   endtask

   initial begin
`ifdef ALU_ARB_RR_EN
      exp_ids = 4'b1010;  // grants 0,1,0,1 (bit k = op k)
`else
      exp_ids = 4'b0000;
`endif
      rst = 1'b1;
      rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_data1 = '0; req0_data2 = '0; req0_ctrl = '0;
      req1_valid = 1'b0; req1_data1 = '0; req1_data2 = '0; req1_ctrl = '0;
      #12;
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Single add 5+7 from requester 0
      req0_valid = 1'b1; req0_data1 = 32'd5; req0_data2 = 32'd7; req0_ctrl = 3'b011;
      #1;
      check("add_rdy0", 32'(req0_ready), 32'd1);
      check("add_rdy1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      check("add_exec_ctrl", 32'(alu_ctrl), 32'd3);
      check("add_exec_rspv", 32'(rsp_valid), 32'd0);
      tick();
      check("add_rspv", 32'(rsp_valid), 32'd1);
      check("add_rspid", 32'(rsp_id), 32'd0);
      check("add_rspd", rsp_data, 32'd12);
      tick();
      check("add_back_idle", 32'(rsp_valid), 32'd0);

      // Multiply -3*4 from requester 1, operands held three cycles
      req1_valid = 1'b1; req1_data1 = 32'hFFFF_FFFD; req1_data2 = 32'd4; req1_ctrl = 3'b101;
      #1;
      check("mul_rdy1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         check("mul_alu1", alu_data1, 32'hFFFF_FFFD);
         check("mul_alu2", alu_data2, 32'd4);
         check("mul_aluc", 32'(alu_ctrl), 32'd5);
         check("mul_rspv_low", 32'(rsp_valid), 32'd0);
         tick();
      end
      check("mul_rspv", 32'(rsp_valid), 32'd1);
      check("mul_rspid", 32'(rsp_id), 32'd1);
      check("mul_rspd", rsp_data, 32'hFFFF_FFF4);
      tick();

      // Contention: both valid continuously
      req0_valid = 1'b1; req0_data1 = 32'd1;  req0_data2 = 32'd2;  req0_ctrl = 3'b011;
      req1_valid = 1'b1; req1_data1 = 32'd10; req1_data2 = 32'd20; req1_ctrl = 3'b011;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("cont_rdy0", 32'(req0_ready), 32'(!exp_ids[k]));
         check("cont_rdy1", 32'(req1_ready), 32'(exp_ids[k]));
         tick();
         tick();
         check("cont_rspid", 32'(rsp_id), 32'(exp_ids[k]));
         check("cont_rspd", rsp_data, exp_ids[k] ? 32'd30 : 32'd3);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // Backpressure: 100+23 from requester 0, requester 1 pending (7+8)
      req0_valid = 1'b1; req0_data1 = 32'd100; req0_data2 = 32'd23; req0_ctrl = 3'b011;
      #1;
      check("bp_rdy0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_data1 = 32'd7; req1_data2 = 32'd8; req1_ctrl = 3'b011;
      tick();
      for (int c = 0; c < 5; c++) begin
         check("bp_rspv", 32'(rsp_valid), 32'd1);
         check("bp_rspid", 32'(rsp_id), 32'd0);
         check("bp_rspd", rsp_data, 32'd123);
         check("bp_rdy0", 32'(req0_ready), 32'd0);
         check("bp_rdy1", 32'(req1_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_no_turnaround", 32'(req1_ready), 32'd0);
      tick();
      check("bp_idle_rspv", 32'(rsp_valid), 32'd0);
      check("bp_pending_rdy1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      check("bp2_rspid", 32'(rsp_id), 32'd1);
      check("bp2_rspd", rsp_data, 32'd15);
      tick();

      // Operand capture: inputs changed during EXEC must not matter
      req0_valid = 1'b1; req0_data1 = 32'h8000_0000; req0_data2 = 32'd4; req0_ctrl = 3'b110;
      tick();
      req0_valid = 1'b0; req0_data1 = 32'd0; req0_data2 = 32'd0; req0_ctrl = 3'b011;
      check("cap_alu1", alu_data1, 32'h8000_0000);
      check("cap_aluc", 32'(alu_ctrl), 32'd6);
      tick();
      check("cap_rspv", 32'(rsp_valid), 32'd1);
      check("cap_rspd", rsp_data, 32'hF800_0000);
      tick();

      // Reset in the second EXEC cycle of a multiply
      req0_valid = 1'b1; req0_data1 = 32'd6; req0_data2 = 32'd7; req0_ctrl = 3'b101;
      tick();
      req0_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      tick();
      tick();
      check_reset_outputs("rst_held");
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Subtract 10-3 after reset
      req0_valid = 1'b1; req0_data1 = 32'd10; req0_data2 = 32'd3; req0_ctrl = 3'b100;
      #1;
      check("sub_rdy0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      check("sub_rspv", 32'(rsp_valid), 32'd1);
      check("sub_rspid", 32'(rsp_id), 32'd0);
      check("sub_rspd", rsp_data, 32'd7);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one combinational ALU between two requesters (e.g. the execute stage and a multi-cycle helper unit). It arbitrates the requesters, captures one request's operands, and drives them onto the ALU for a fixed number of cycles. It then registers the result and returns it over a valid/ready response channel tagged with the requester ID. Multiply (ctrl 3'b101) is held for a configurable number of cycles so the ALU's multiplier path can be multicycle-constrained in synthesis.

## Interface
Parameters:
- MUL_CYCLES, 3, cycles operands are held on the ALU for ctrl 3'b101; legal range 1..15
- OTHER_CYCLES, fixed 1 (not a parameter), cycles for every other ctrl code

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 accepted this cycle
- req0_data1_i, req0_data2_i  input  32  operands
- req0_ctrl_i  input  3  ALU control code
- req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i  same as requester 0
- alu_data1_o, alu_data2_o  output  32  operands to ALU
- alu_ctrl_o  output  3  control to ALU
- alu_result_i  input  32  ALU result, combinational from alu_* outputs
- rsp_valid_o  output  1  response available
- rsp_ready_i  input  1  consumer takes response
- rsp_id_o  output  1  requester that issued the response
- rsp_data_o  output  32  registered result

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: ready_o 0 on both requesters, alu_* 0, rsp_valid_o 0, rsp_id_o 0, rsp_data_o 0, counter 0, last_grant 1.
- IDLE:
  - A requester is granted if its valid is high; tie-break per Configuration.
  - reqN_ready_o is high, combinationally, only for the granted requester and only in IDLE. Acceptance is valid & ready.
  - On acceptance: capture data1, data2 and ctrl into operand registers; record grant id into last_grant and rsp_id; load counter with (ctrl==3'b101 ? MUL_CYCLES : 1) - 1; go to EXEC.
- EXEC:
  - alu_* are driven from the operand registers. They are stable for the whole EXEC period and hold their last value in other states.
  - If counter != 0, decrement. If counter == 0, register alu_result_i into rsp_data_o and go to RESP.
- RESP:
  - rsp_valid_o is 1; rsp_id_o and rsp_data_o are held stable.
  - Both ready_o are 0.
  - When rsp_ready_i is high, go to IDLE. New requests are accepted only from the following cycle, so there is no same-cycle turnaround.
- Undefined ctrl (3'b111) executes for 1 cycle; the result is whatever the ALU returns (0).
- Requester inputs are ignored after capture. Changing them mid-operation has no effect.
- rst_i asserted in any state returns to IDLE immediately with reset values. The in-flight operation is dropped and no response is produced.

## Timing
- Cycle 0: valid & ready, acceptance edge at the end of cycle 0.
- Non-multiply: EXEC in cycle 1; rsp_valid_o is high from cycle 2.
- Multiply: EXEC in cycles 1..MUL_CYCLES; rsp_valid_o is high from cycle MUL_CYCLES+1.
- Response accepted in cycle R returns the block to IDLE in cycle R+1. Best-case throughput is one operation per 3 cycles for non-multiply operations.
- ready_o depends combinationally on valid_i and state. valid_i must not depend on ready_o.

## Configuration
- ALU_ARB_RR_EN defined: round-robin. On a tie, grant the requester that is not last_grant. A lone valid requester is always granted.
- ALU_ARB_RR_EN undefined: fixed priority. Requester 0 always wins a tie, and requester 1 can be starved. last_grant is still maintained but unused.

## Test plan
- Single add: req0 data1=5, data2=7, ctrl=3'b011 -> req0_ready_o=1 in cycle 0; alu_ctrl_o=3'b011 in cycle 1; rsp_valid_o=1, rsp_id_o=0, rsp_data_o=12 in cycle 2.
- Multiply, MUL_CYCLES=3: req1 data1=-3, data2=4, ctrl=3'b101 -> alu_* stable in cycles 1-3; rsp_valid_o in cycle 4; rsp_id_o=1, rsp_data_o=32'hFFFFFFF4.
- Contention, both valid continuously, rsp_ready_i=1:
  - With ALU_ARB_RR_EN, grant order is 0,1,0,1.
  - Without it, grant order is 0,0,0,0.
- Backpressure: rsp_ready_i low for 5 cycles after response -> rsp_valid_o, rsp_id_o and rsp_data_o stable; both ready_o 0. Raise rsp_ready_i -> IDLE the next cycle, and a pending request is accepted there.
- Operand capture: req0 data1=32'h80000000, data2=4, ctrl=3'b110; change req0 inputs in cycle 1 -> rsp_data_o=32'hF8000000.
- Reset mid-multiply: assert rst_i in EXEC cycle 2 -> all outputs at reset values asynchronously; no response appears. After release, a subtract 10-3 (ctrl 3'b100) completes normally with result 7.
